// File: rtl/pipe_seg_reg.sv
// Pipeline segment register with valid/ready handshake, optional skid entry,
// stall/flush controls and a configurable bubble value for empty slots.
module pipe_seg_reg #(
  parameter int unsigned        DATA_W = 32,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned        SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic [1:0]        count_q;
  logic              rdy_q;
  logic              in_fire;
  logic              out_fire;
  logic              rdy_base;

  // Skid build exposes a registered ready; single-entry build passes out_ready through.
  assign rdy_base    = (SKID != 0) ? rdy_q : ((state_q == ST_EMPTY) || out_ready_i);
  assign in_ready_o  = rdy_base & ~stall_i & ~rst_i;
  assign out_valid_o = (state_q != ST_EMPTY) & ~stall_i & ~rst_i;
  assign out_data_o  = main_q;
  assign count_o     = count_q;

  assign in_fire  = in_valid_i & in_ready_o;
  assign out_fire = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else if (stall_i) begin
      state_q <= state_q;
    end else if (flush_i) begin
      // Flush drops every held beat and any beat arriving this cycle.
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      count_q <= 2'd0;
      rdy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_q  <= in_data_i;
            state_q <= ST_BUSY;
            count_q <= 2'd1;
          end
        end
        ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_q <= in_data_i;
          end else if (in_fire && (SKID != 0)) begin
            skid_q  <= in_data_i;
            state_q <= ST_FULL;
            count_q <= 2'd2;
            rdy_q   <= 1'b0;
          end else if (in_fire) begin
            main_q <= in_data_i;
          end else if (out_fire) begin
            main_q  <= BUBBLE;
            state_q <= ST_EMPTY;
            count_q <= 2'd0;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_q  <= skid_q;
            skid_q  <= BUBBLE;
            state_q <= ST_BUSY;
            count_q <= 2'd1;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
          count_q <= 2'd0;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule
